hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS32 core.
- Sequences the PC, IF/ID and ID/EX pipeline registers: write enables, flushes and bubble insertion into ID/EX (all control bits zeroed).
- Sources of stalls and flushes:
  - load-use hazards, from ID/EX MemToRead/RT against the IF/ID RS/RT fields;
  - taken branches resolved in MEM;
  - a data-memory busy handshake.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles per load-use hazard (1 = EX forwarding present, 2 = no forwarding); legal 1..3.
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a taken branch; legal 1..3.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  RS field of instruction in IF/ID
- id_rt  in  5  RT field of instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads RT as source (R-type, store, beq)
- ex_mem_read  in  1  MemToRead of ID/EX stage
- ex_rt  in  5  RT destination of ID/EX stage
- mem_branch_taken  in  1  Branch & Zero in EX/MEM stage
- mem_busy  in  1  data memory not ready; pipeline must freeze
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  ID/EX enable
- id_ex_bubble  out  1  zero all ID/EX control fields on this edge
- ex_mem_flush  out  1  clear EX/MEM control fields
- state_o  out  2  current FSM state (debug)
- stall_count  out  CNT_W  load-use stall cycles (see Optional Feature)
- flush_count  out  CNT_W  flush cycles (see Optional Feature)

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- States: RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3. Single counter cnt, 2 bits. Reset: state=RUN, cnt=0, counters=0.
- While rst_n=0 outputs are forced: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=1, if_id_flush=1, ex_mem_flush=0.
- Outputs are combinational from state and current inputs (zero-latency stall). State and cnt update on the rising edge of clk.
- Hazard condition: hz = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Priority, all states: mem_busy > mem_branch_taken > hz.
- mem_busy=1, any state:
  - all enables 0, all flush/bubble 0 (full freeze);
  - next state MEM_WAIT; cnt and the return state are saved.
- MEM_WAIT with mem_busy=0:
  - returns to the saved state with cnt unchanged;
  - outputs that cycle are those of the saved state.
- Taken branch (mem_branch_taken=1, not busy):
  - pc_write=1, if_id_flush=1, id_ex_bubble=1, id_ex_write=1, ex_mem_flush=1;
  - if FLUSH_CYCLES>1: next FLUSH with cnt=FLUSH_CYCLES-2; else next RUN.
  - A taken branch during LOAD_STALL aborts the stall.
- FLUSH: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, id_ex_write=1. When cnt=0 go to RUN, else decrement cnt.
- Load-use (RUN, hz=1):
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1;
  - if LOAD_STALL_CYCLES>1: next LOAD_STALL with cnt=LOAD_STALL_CYCLES-2; else stay in RUN.
- LOAD_STALL: same outputs as load-use, regardless of hz. When cnt=0 go to RUN, else decrement cnt.
- RUN, no event: all enables 1, flush/bubble 0.
- Reset asserted mid-stall or mid-flush: immediate return to RUN with cnt=0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stall_count increments every cycle with id_ex_bubble=1 caused by load-use;
  - flush_count increments every cycle with if_id_flush=1 outside reset;
  - both saturate at all-ones, hold during MEM_WAIT, and clear on reset.
- Undefined: both ports tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset: rst_n=0 mid-run → outputs forced as listed, state_o=0. After release with no hazards → pc_write=if_id_write=id_ex_write=1.
- Load-use, LOAD_STALL_CYCLES=1: ex_mem_read=1, ex_rt=8, id_rs=8 → exactly 1 cycle of pc_write=0, id_ex_bubble=1, then RUN. With ex_rt=0 → no stall. With id_rt=8 and id_uses_rt=0 → no stall.
- Load-use, LOAD_STALL_CYCLES=2: same stimulus held for 1 cycle → 2 consecutive bubble cycles, state_o=1 during the second.
- Branch, FLUSH_CYCLES=2: mem_branch_taken pulse → 2 cycles of if_id_flush=1, ex_mem_flush=1 in the first cycle only, then RUN.
- Busy: mem_busy high 3 cycles during LOAD_STALL → all enables 0 for 3 cycles, state_o=3. After release, the remaining stall completes.
- Simultaneous: mem_branch_taken=1 with hz=1 → flush outputs, no pc freeze. With HAZARD_STATS_EN: flush_count=1, stall_count=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS32 pipeline: load-use stalls, branch flushes, memory-busy freeze.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [1:0] LS_INIT = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [1:0] FL_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    state_t     eff_state;
    logic [1:0] cnt_q, cnt_d;
    logic       hz;
    logic       in_wait;

    assign hz = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign in_wait   = (state_q == MEM_WAIT);
    // Leaving MEM_WAIT replays the interrupted state's behaviour for one cycle.
    assign eff_state = in_wait ? ret_q : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;

        if (mem_busy) begin
            state_d = MEM_WAIT;
            if (!in_wait) begin
                ret_d = state_q;
            end
        end else if (mem_branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_d        = FL_INIT;
        end else begin
            case (eff_state)
                FLUSH: begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    id_ex_write  = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                LOAD_STALL: begin
                    id_ex_write  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    if (hz) begin
                        id_ex_write  = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LS_INIT;
                        end
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        id_ex_write = 1'b1;
                    end
                end
            endcase
            // The replay cycle resumes the saved state without consuming its count.
            if (in_wait) begin
                state_d = ret_q;
                cnt_d   = cnt_q;
            end
        end

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            ex_mem_flush = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             load_use_bub;

    // A bubble without an IF/ID flush can only come from a load-use stall.
    assign load_use_bub = id_ex_bubble && !if_id_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!in_wait) begin
            if (load_use_bub && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (if_id_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
